otter_rf_wb_ctrl: RTL and testbench

OTTER_RF_WB_CTRL -- requirements
Module: otter_rf_wb_ctrl

---
 rtl/otter_rf_pkg.sv | 14 +
 rtl/otter_rr_arb2.sv | 47 ++++
 rtl/otter_rf_wb_ctrl.sv | 132 +++++++++++++
 tb/tb_otter_rf_wb_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_rf_pkg.sv
// Shared widths and writeback-source encoding for the OTTER register-file
// writeback controller and its arbiter.
package otter_rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/otter_rr_arb2.sv
// Two-way round-robin arbiter: req/gnt bit 0 is the ALU, bit 1 is MEM.
// The pointer names the requester favoured on the next contention.
module otter_rr_arb2
  import otter_rf_pkg::*;
#(
  parameter int FIRST_PRIO = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e prio_reg, prio_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_reg <= (FIRST_PRIO != 0) ? WB_MEM : WB_ALU;
    end else begin
      prio_reg <= prio_next;
    end
  end

  always_comb begin
    gnt       = 2'b00;
    prio_next = prio_reg;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        // Contention: grant the favoured side, then favour the loser.
        if (prio_reg == WB_ALU) begin
          gnt       = 2'b01;
          prio_next = WB_MEM;
        end else begin
          gnt       = 2'b10;
          prio_next = WB_ALU;
        end
      end
      default: ;
    endcase
    if (!reset_n) begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/otter_rf_wb_ctrl.sv
// Register-file writeback controller: arbitrates ALU/MEM writebacks, registers
// the RF write port and keeps the issue scoreboard. Optional OTTER_RF_WB_FWD_EN.
module otter_rf_wb_ctrl
  import otter_rf_pkg::*;
#(
  parameter int FIRST_PRIO = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  output logic                  hazard,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  mem_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wa,
  output logic [XLEN-1:0]       rf_wd,
  output logic [NUM_REGS-1:0]   busy,
`ifdef OTTER_RF_WB_FWD_EN
  output logic                  fwd_rs1,
  output logic                  fwd_rs2,
`endif
  output logic                  wb_err
);

  logic [1:0]            req, gnt;
  wb_src_e               wb_sel;
  logic [REG_ADDR_W-1:0] xfer_rd;
  logic [XLEN-1:0]       xfer_data;

  logic                  rf_we_reg;
  logic [REG_ADDR_W-1:0] rf_wa_reg;
  logic [XLEN-1:0]       rf_wd_reg;
  logic [NUM_REGS-1:0]   busy_reg, busy_next, busy_eff;
  logic                  wb_err_reg;
  logic                  issue_accept;

  assign req = {mem_valid, alu_valid};

  otter_rr_arb2 #(
    .FIRST_PRIO(FIRST_PRIO)
  ) u_arb (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (req),
    .gnt    (gnt)
  );

  assign alu_ready = gnt[0];
  assign mem_ready = gnt[1];

  always_comb begin
    wb_sel    = gnt[1] ? WB_MEM : WB_ALU;
    xfer_rd   = alu_rd;
    xfer_data = alu_data;
    if (wb_sel == WB_MEM) begin
      xfer_rd   = mem_rd;
      xfer_data = mem_data;
    end
  end

  // Writes to x0 are consumed here and never reach the register file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_reg <= 1'b0;
      rf_wa_reg <= '0;
      rf_wd_reg <= '0;
    end else begin
      rf_we_reg <= (|gnt) && (xfer_rd != '0);
      if (|gnt) begin
        rf_wa_reg <= xfer_rd;
        rf_wd_reg <= xfer_data;
      end
    end
  end

`ifdef OTTER_RF_WB_FWD_EN
  // The register being written this cycle is readable through rf_wd.
  assign busy_eff = rf_we_reg ? (busy_reg & ~({{(NUM_REGS-1){1'b0}}, 1'b1} << rf_wa_reg))
                              : busy_reg;
  assign fwd_rs1  = rf_we_reg && (rf_wa_reg != '0) && (issue_rs1 == rf_wa_reg);
  assign fwd_rs2  = rf_we_reg && (rf_wa_reg != '0) && (issue_rs2 == rf_wa_reg);
`else
  assign busy_eff = busy_reg;
`endif

  assign hazard       = reset_n && issue_valid &&
                        (busy_eff[issue_rs1] || busy_eff[issue_rs2] || busy_eff[issue_rd]);
  assign issue_accept = issue_valid && !hazard && (issue_rd != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_bit, clr_bit;
        assign set_bit = issue_accept && (issue_rd == REG_ADDR_W'(gi));
        assign clr_bit = rf_we_reg && (rf_wa_reg == REG_ADDR_W'(gi));
        // A new issue to the register retiring this edge keeps it pending.
        assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg   <= '0;
      wb_err_reg <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      if (rf_we_reg && (rf_wa_reg != '0) && !busy_reg[rf_wa_reg]) begin
        wb_err_reg <= 1'b1;
      end
    end
  end

  assign rf_we  = rf_we_reg;
  assign rf_wa  = rf_wa_reg;
  assign rf_wd  = rf_wd_reg;
  assign busy   = busy_reg;
  assign wb_err = wb_err_reg;

endmodule

// File: tb/tb_otter_rf_wb_ctrl.sv
// Bench for otter_rf_wb_ctrl: directed scenarios then randomized traffic, all
// checked against a set-of-pending-registers model.
module tb_otter_rf_wb_ctrl;
  localparam int FIRST_PRIO = 0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
  logic        hazard;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy;
  logic        wb_err;
`ifdef OTTER_RF_WB_FWD_EN
  logic        fwd_rs1, fwd_rs2;
`endif

  otter_rf_wb_ctrl #(.FIRST_PRIO(FIRST_PRIO)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .hazard(hazard),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy),
`ifdef OTTER_RF_WB_FWD_EN
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
`endif
    .wb_err(wb_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: set of pending registers, one in-flight write, sticky error.
  bit          m_busy[32];
  bit          m_we, m_err;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_fav;
  bit          last_ga, last_gm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit pending(input logic [4:0] r);
`ifdef OTTER_RF_WB_FWD_EN
    if (m_we && r == m_wa) return 1'b0;
`endif
    return m_busy[r];
  endfunction

  function automatic logic [4:0] pick_rd();
    logic [4:0] r;
    for (int t = 0; t < 8; t++) begin
      r = 5'($urandom_range(1, 15));
      if (m_busy[r]) return r;
    end
    return 5'($urandom_range(0, 15));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_we = 1'b0; m_err = 1'b0; m_wa = '0; m_wd = '0;
    m_fav = FIRST_PRIO;
    last_ga = 1'b0; last_gm = 1'b0;
  endtask

  task automatic idle();
    issue_valid = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
  endtask

  // One clock cycle: compare everything with the model, then advance the model.
  task automatic step();
    bit ga, gm, haz;
    logic [31:0] exp_busy;
    logic [4:0]  rd;
    logic [31:0] data;
    #1;
    ga  = alu_valid && (!mem_valid || m_fav == 0);
    gm  = mem_valid && (!alu_valid || m_fav == 1);
    haz = issue_valid && (pending(issue_rs1) || pending(issue_rs2) || pending(issue_rd));
    for (int i = 0; i < 32; i++) exp_busy[i] = m_busy[i];
    check("alu_ready", 32'(alu_ready), 32'(ga));
    check("mem_ready", 32'(mem_ready), 32'(gm));
    check("hazard", 32'(hazard), 32'(haz));
    check("rf_we", 32'(rf_we), 32'(m_we));
    if (m_we) begin
      check("rf_wa", 32'(rf_wa), 32'(m_wa));
      check("rf_wd", rf_wd, m_wd);
    end
    check("busy", busy, exp_busy);
    check("wb_err", 32'(wb_err), 32'(m_err));
`ifdef OTTER_RF_WB_FWD_EN
    check("fwd_rs1", 32'(fwd_rs1), 32'(m_we && issue_rs1 == m_wa && issue_rs1 != 0));
    check("fwd_rs2", 32'(fwd_rs2), 32'(m_we && issue_rs2 == m_wa && issue_rs2 != 0));
`endif
    if (alu_valid && mem_valid) m_fav = ga ? 1 : 0;
    if (m_we) begin
      if (!m_busy[m_wa]) m_err = 1'b1;
      m_busy[m_wa] = 1'b0;
    end
    if (issue_valid && !haz && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (ga || gm) begin
      rd   = ga ? alu_rd : mem_rd;
      data = ga ? alu_data : mem_data;
      m_we = (rd != 0); m_wa = rd; m_wd = data;
      $display("wb %s rd=%0d data=%h", ga ? "alu" : "mem", rd, data);
    end else begin
      m_we = 1'b0;
    end
    last_ga = ga; last_gm = gm;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Asserted mid-cycle so the asynchronous clear is visible before any edge.
  task automatic do_reset();
    alu_valid = 1'b1; mem_valid = 1'b1; issue_valid = 1'b1; issue_rd = 5'd1;
    reset_n = 1'b0;
    #1;
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_hazard", 32'(hazard), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_wa", 32'(rf_wa), 32'd0);
    check("rst_rf_wd", rf_wd, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_wb_err", 32'(wb_err), 32'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle();
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    do_reset();

    // Issue then ALU writeback of x5.
    issue_valid = 1'b1; issue_rd = 5'd5; step();
    idle(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check("t031_alu_ready", 32'(alu_ready), 32'd1);
    step();
    idle();
    #1;
    check("t031_rf_we", 32'(rf_we), 32'd1);
    check("t031_rf_wa", 32'(rf_wa), 32'd5);
    check("t031_rf_wd", rf_wd, 32'hDEADBEEF);
    step();
    #1 check("t031_busy5", 32'(busy[5]), 32'd0);
    check("t031_wb_err", 32'(wb_err), 32'd0);

    // Read-after-write stall on x7.
    issue_valid = 1'b1; issue_rd = 5'd7; step();
    issue_rd = 5'd8; issue_rs1 = 5'd7;
    #1 check("t033_hazard_busy", 32'(hazard), 32'd1);
    step();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0777; step();
    alu_valid = 1'b0;
    #1;
    check("t033_rf_we", 32'(rf_we), 32'd1);
`ifdef OTTER_RF_WB_FWD_EN
    check("t033_hazard_fwd", 32'(hazard), 32'd0);
    check("t033_fwd_rs1", 32'(fwd_rs1), 32'd1);
`else
    check("t033_hazard_wb", 32'(hazard), 32'd1);
`endif
    step();
    #1 check("t033_hazard_clear", 32'(hazard), 32'd0);
    step();
    idle();

    // Contention alternates ALU, MEM, ALU, MEM.
    issue_valid = 1'b1; issue_rd = 5'd3; step();
    issue_rd = 5'd4; step();
    idle();
    alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd3; mem_rd = 5'd4;
    alu_data = 32'h0000_00A0; mem_data = 32'h0000_00B0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t032_alu_grant", 32'(alu_ready), 32'(k % 2 == 0));
      check("t032_mem_grant", 32'(mem_ready), 32'(k % 2 == 1));
      step();
    end
    idle();
    #1 check("t032_rf_we_last", 32'(rf_we), 32'd1);
    step();

    // Reset one cycle after a grant drops the pending write.
    issue_valid = 1'b1; issue_rd = 5'd10; step();
    idle(); alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h1010_1010; step();
    do_reset();
    #1;
    check("t036_rf_we", 32'(rf_we), 32'd0);
    check("t036_busy", busy, 32'd0);
    check("t036_wb_err", 32'(wb_err), 32'd0);
    step();
    step();

    // Writeback to a non-busy register, set-vs-clear, and x0 writeback.
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h1212_1212; step();
    idle();
    #1;
    check("t035_rf_we", 32'(rf_we), 32'd1);
    check("t035_rf_wa", 32'(rf_wa), 32'd12);
    step();
    #1 check("t035_wb_err", 32'(wb_err), 32'd1);
    step();
    step();
    #1 check("t035_wb_err_sticky", 32'(wb_err), 32'd1);
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h0909_0909; step();
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; step();
    idle();
    #1 check("t034_busy9", 32'(busy[9]), 32'd1);
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF_FFFF;
    #1 check("t034_rd0_ready", 32'(mem_ready), 32'd1);
    step();
    idle();
    #1 check("t034_rd0_no_we", 32'(rf_we), 32'd0);
    step();
    do_reset();

    // Randomized traffic; held requests keep rd/data until granted.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if (!(alu_valid && !last_ga)) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = pick_rd();
        alu_data  = $urandom;
      end
      if (!(mem_valid && !last_gm)) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = pick_rd();
        mem_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) != 0);
      issue_rd    = 5'($urandom_range(0, 15));
      issue_rs1   = 5'($urandom_range(0, 15));
      issue_rs2   = 5'($urandom_range(0, 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
